surf_cmd_serializer: RTL



---
 rtl/turf_cmd_pkg.sv | 34 +++
 rtl/surf_cmd_serializer_if.sv | 32 +++
 rtl/cmd_bit_timer.sv | 46 ++++
 rtl/surf_cmd_serializer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/turf_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turf_cmd_pkg
// Purpose  : Shared command-type codes, frame geometry, FSM encoding and the
//            frame builder for the SURF CMD serializer.
// Revision : 1.0
// ============================================================================
package turf_cmd_pkg;

    localparam logic [1:0] CMD_TYPE_TRIG     = 2'b00;
    localparam logic [1:0] CMD_TYPE_CLEAR    = 2'b01;
    localparam logic [1:0] CMD_TYPE_EVID_RST = 2'b10;

    localparam int CMD_FRAME_BITS = 38;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } cmd_state_t;

    // Start bit, 36 payload bits, then odd parity over the payload.
    function automatic logic [CMD_FRAME_BITS-1:0] build_frame(
        input logic [1:0]  cmd_type,
        input logic [1:0]  cmd_buffer,
        input logic [31:0] cmd_evid
    );
        logic [35:0] payload;
        payload = {cmd_type, cmd_buffer, cmd_evid};
        return {1'b1, payload, ~(^payload)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/surf_cmd_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : surf_cmd_serializer_if
// Purpose  : Command handshake and CMD-lane bundle between the trigger
//            interface (master) and the serializer (slave).
// Revision : 1.0
// ============================================================================
interface surf_cmd_serializer_if #(
    parameter int NUM_SURFS = 12
);
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [1:0]           cmd_type_i;
    logic [1:0]           cmd_buffer_i;
    logic [31:0]          cmd_evid_i;
    logic [NUM_SURFS-1:0] cmd_mask_i;
    logic [NUM_SURFS-1:0] cmd_o;
    logic                 busy_o;
    logic                 frame_done_o;
    logic [15:0]          frame_count_o;

    modport master (
        output cmd_valid_i, cmd_type_i, cmd_buffer_i, cmd_evid_i, cmd_mask_i,
        input  cmd_ready_o, cmd_o, busy_o, frame_done_o, frame_count_o
    );

    modport slave (
        input  cmd_valid_i, cmd_type_i, cmd_buffer_i, cmd_evid_i, cmd_mask_i,
        output cmd_ready_o, cmd_o, busy_o, frame_done_o, frame_count_o
    );
endinterface
`default_nettype wire

// File: rtl/cmd_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_bit_timer
// Purpose  : BIT_CLKS prescaler producing a bit_tick strobe on the last clock
//            of each bit-time, plus a 6-bit bit index; restartable.
// Revision : 1.0
// ============================================================================
module cmd_bit_timer #(
    parameter int BIT_CLKS = 2
) (
    input  wire logic       clk250_i,
    input  wire logic       rst_n_i,
    input  wire logic       restart,
    input  wire logic       run,
    output logic            bit_tick,
    output logic [5:0]      bit_idx
);

    localparam int               CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_idx;

    assign bit_tick = run && (r_cnt == CNT_LAST);
    assign bit_idx  = r_idx;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (restart) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (run) begin
            if (bit_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 6'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/surf_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : surf_cmd_serializer
// Purpose  : Serializes accepted trigger/clear commands into 38-bit framed
//            bitstreams on the per-SURF CMD lanes, with an enforced idle gap.
// Revision : 1.0
// ============================================================================
module surf_cmd_serializer
    import turf_cmd_pkg::*;
#(
    parameter int NUM_SURFS = 12,
    parameter int BIT_CLKS  = 2,
    parameter int GAP_BITS  = 4
) (
    input  wire logic            clk250_i,
    input  wire logic            rst_n_i,
    input  wire logic            clr_i,
    surf_cmd_serializer_if.slave cmd_if
);

    localparam logic [5:0] LAST_BIT_IDX = 6'(CMD_FRAME_BITS - 1);
    localparam logic [5:0] LAST_GAP_IDX = 6'(GAP_BITS - 1);

    cmd_state_t                r_state;
    cmd_state_t                w_state_next;
    logic [CMD_FRAME_BITS-1:0] r_shift;
    logic [CMD_FRAME_BITS-1:0] w_frame;
    logic [NUM_SURFS-1:0]      r_mask;
    logic [NUM_SURFS-1:0]      r_cmd;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;
    logic [15:0]               r_frame_count;

    logic                      w_accept;
    logic                      w_tick;
    logic [5:0]                w_idx;
    logic                      w_last_bit;
    logic                      w_gap_done;
    logic                      w_timer_restart;
    logic                      w_timer_run;

    // clr_i gates ready combinationally so a command offered during clear is refused.
    assign w_accept   = cmd_if.cmd_valid_i && r_ready && !clr_i;
    assign w_last_bit = (r_state == ST_SHIFT) && w_tick && (w_idx == LAST_BIT_IDX);
    assign w_gap_done = (r_state == ST_GAP)   && w_tick && (w_idx == LAST_GAP_IDX);
    assign w_frame    = build_frame(cmd_if.cmd_type_i, cmd_if.cmd_buffer_i, cmd_if.cmd_evid_i);

    assign w_timer_restart = w_accept || w_last_bit || clr_i;
    assign w_timer_run     = (r_state != ST_IDLE) && !clr_i;

    cmd_bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_timer (
        .clk250_i (clk250_i),
        .rst_n_i  (rst_n_i),
        .restart  (w_timer_restart),
        .run      (w_timer_run),
        .bit_tick (w_tick),
        .bit_idx  (w_idx)
    );

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept)   w_state_next = ST_SHIFT;
                ST_SHIFT: if (w_last_bit) w_state_next = ST_GAP;
                ST_GAP:   if (w_gap_done) w_state_next = ST_IDLE;
                default:                  w_state_next = ST_IDLE;
            endcase
        end
    end

    // The start bit is driven at the accept edge; r_shift holds the bits still to go, MSB first.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift       <= '0;
            r_mask        <= '0;
            r_cmd         <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_ready <= (w_state_next == ST_IDLE);
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= w_last_bit && !clr_i;
            if (clr_i) begin
                r_cmd         <= '0;
                r_frame_count <= '0;
            end else if (w_accept) begin
                r_shift <= w_frame << 1;
                r_mask  <= cmd_if.cmd_mask_i;
                r_cmd   <= ~cmd_if.cmd_mask_i;
            end else if (w_last_bit) begin
                r_cmd         <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else if ((r_state == ST_SHIFT) && w_tick) begin
                r_cmd   <= {NUM_SURFS{r_shift[CMD_FRAME_BITS-1]}} & ~r_mask;
                r_shift <= r_shift << 1;
            end
        end
    end

    assign cmd_if.cmd_ready_o   = r_ready && !clr_i;
    assign cmd_if.cmd_o         = r_cmd;
    assign cmd_if.busy_o        = r_busy;
    assign cmd_if.frame_done_o  = r_done;
    assign cmd_if.frame_count_o = r_frame_count;

endmodule
`default_nettype wire
